// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 transmit arbiter: header tag, FSM encoding
// and a constant-width helper.
package rs232_pkg;

    localparam logic [3:0] HEADER_TAG = 4'hA;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    // Smallest width able to index v distinct values.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs232_tx_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set request at or above ptr,
// wrapping from NUM_PORTS-1 back to 0.
module rr_pick
    import rs232_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [3:0]           ptr,
    output logic                 any,
    output logic [3:0]           idx
);

    logic [4:0] w_cand;
    logic       w_hit;

    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_cand = '0;
        w_hit  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_cand = {1'b0, ptr} + 5'(i);
            if (w_cand >= 5'(NUM_PORTS)) w_cand = w_cand - 5'(NUM_PORTS);
            w_hit = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_cand == 5'(p)) w_hit = req[p];
            end
            if (!any && w_hit) begin
                any = 1'b1;
                idx = w_cand[3:0];
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one byte transmitter between
// NUM_PORTS producers, optionally tagging each grant with a source header.
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int MAX_BURST = 16,
    parameter int HEADER_EN = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [8*NUM_PORTS-1:0] in_data,
    input  logic [NUM_PORTS-1:0]   in_valid,
    input  logic [NUM_PORTS-1:0]   in_last,
    output logic [NUM_PORTS-1:0]   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             grant,
    output logic                   busy
);

    localparam int              CNT_W    = clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t             r_state;
    logic [3:0]         r_grant;
    logic [3:0]         r_rr_ptr;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [7:0]         r_out_data;
    logic               r_out_valid;

    logic                 w_any;
    logic [3:0]           w_idx;
    logic [NUM_PORTS-1:0] w_grant_mask;
    logic [7:0]           w_sel_data;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic                 w_out_free;
    logic                 w_upload;
    logic                 w_download;
    logic [3:0]           w_next_ptr;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .req (in_valid),
        .ptr (r_rr_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    // Route the granted port's byte, valid and last onto the shared path.
    always_comb begin
        w_grant_mask = '0;
        w_sel_data   = '0;
        w_sel_valid  = 1'b0;
        w_sel_last   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_grant == 4'(p)) begin
                w_grant_mask[p] = 1'b1;
                w_sel_data      = in_data[8*p +: 8];
                w_sel_valid     = in_valid[p];
                w_sel_last      = in_last[p];
            end
        end
    end

    assign w_out_free = !r_out_valid || out_ready;
    assign w_download = r_out_valid && out_ready;
    assign w_upload   = (r_state == ST_DATA) && w_out_free && w_sel_valid;
    assign w_next_ptr = (r_grant == 4'(NUM_PORTS - 1)) ? 4'd0 : r_grant + 4'd1;

    assign in_ready  = ((r_state == ST_DATA) && w_out_free) ? w_grant_mask : '0;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign grant     = r_grant;
    assign busy      = (r_state == ST_DATA);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // NOTE: a later non-blocking assignment to the same register in this
            // block wins, so a load below overrides this drain-only clear.
            if (w_download) r_out_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any && w_out_free) begin
                        r_grant     <= w_idx;
                        r_burst_cnt <= '0;
                        r_state     <= ST_DATA;
                        if (HEADER_EN != 0) begin
                            r_out_data  <= {HEADER_TAG, w_idx};
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_upload) begin
                        r_out_data  <= w_sel_data;
                        r_out_valid <= 1'b1;
                        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                        // Packet end or burst cap hands the link to the next port.
                        if (w_sel_last || (r_burst_cnt == CNT_LAST)) begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Bench for rs232_tx_arbiter: cycle table, hand sequences for header-less mode
// and reset, and randomized streams against a packet-level reference model.
module tb_rs232_tx_arbiter;

    localparam int TB_PORTS = 4;
    localparam int TB_BURST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_last, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_ready;
    logic [3:0]  grant;
    logic        busy;

    logic        b_reset;
    logic [15:0] b_in_data;
    logic [1:0]  b_in_valid, b_in_last, b_in_ready;
    logic [7:0]  b_out_data;
    logic        b_out_valid, b_out_ready;
    logic [3:0]  b_grant;
    logic        b_busy;

    always #5 clk = ~clk;

    rs232_tx_arbiter #(.NUM_PORTS(TB_PORTS), .MAX_BURST(TB_BURST), .HEADER_EN(1)) dut (
        .clock(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .grant(grant), .busy(busy)
    );

    rs232_tx_arbiter #(.NUM_PORTS(2), .MAX_BURST(16), .HEADER_EN(0)) dut_nohdr (
        .clock(clk), .reset(b_reset), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_last(b_in_last), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .grant(b_grant), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic [7:0] d;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic [3:0] ir;
        logic [3:0] g;
        logic       b;
    } vec_t;

    vec_t vecs[14];

    // Per-port source streams: bit 8 is in_last, bits 7:0 the byte.
    logic [8:0] src [TB_PORTS][64];
    int         src_len [TB_PORTS];
    int         src_pos [TB_PORTS];
    logic [7:0] cap_q[$];
    int         cap_cyc[$];
    logic [7:0] exp_q[$];

    task automatic clear_src();
        for (int p = 0; p < TB_PORTS; p++) begin
            src_len[p] = 0;
            src_pos[p] = 0;
        end
        cap_q.delete();
        cap_cyc.delete();
        exp_q.delete();
    endtask

    task automatic add_pkt(input int p, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            src[p][src_len[p]] = {(i == n - 1), base + 8'(i)};
            src_len[p]++;
        end
    endtask

    // Reference: round-robin over ports holding data, one header per grant,
    // grant ends on last or after TB_BURST payload bytes.
    task automatic build_expected();
        int  pos[TB_PORTS];
        int  ptr, p, n;
        bit  found, done;
        for (int i = 0; i < TB_PORTS; i++) pos[i] = 0;
        ptr = 0;
        forever begin
            found = 0;
            p = 0;
            for (int i = 0; i < TB_PORTS; i++) begin
                int q;
                q = (ptr + i) % TB_PORTS;
                if (!found && pos[q] < src_len[q]) begin
                    found = 1;
                    p = q;
                end
            end
            if (!found) break;
            exp_q.push_back(8'hA0 | 8'(p));
            n = 0;
            done = 0;
            while (!done && n < TB_BURST) begin
                exp_q.push_back(src[p][pos[p]][7:0]);
                done = src[p][pos[p]][8];
                pos[p]++;
                n++;
            end
            ptr = (p + 1) % TB_PORTS;
        end
    endtask

    task automatic run_stream(input int rdy_pct, input string tag);
        int cyc = 0;
        while (cap_q.size() < exp_q.size() && cyc < 3000) begin
            @(posedge clk); #1;
            for (int p = 0; p < TB_PORTS; p++) begin
                if (src_pos[p] < src_len[p]) begin
                    in_valid[p]         = 1'b1;
                    in_data[8*p +: 8]   = src[p][src_pos[p]][7:0];
                    in_last[p]          = src[p][src_pos[p]][8];
                end else begin
                    in_valid[p]         = 1'b0;
                    in_data[8*p +: 8]   = 8'h00;
                    in_last[p]          = 1'b0;
                end
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            check({tag, "_onehot"}, 32'($onehot0(in_ready)), 32'd1);
            if (out_valid && !out_ready) check({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
            for (int p = 0; p < TB_PORTS; p++) begin
                if (in_valid[p] && in_ready[p]) src_pos[p]++;
            end
            if (out_valid && out_ready) begin
                cap_q.push_back(out_data);
                cap_cyc.push_back(cyc);
            end
            cyc++;
        end
        @(posedge clk); #1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        check({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; b_reset = 1'b1;
        in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
        b_in_data = '0; b_in_valid = '0; b_in_last = '0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; b_reset = 1'b0;

        // v, l, d, out_ready | out_valid, out_data, in_ready, grant, busy
        vecs[0]  = '{4'b0100, 4'b0000, 8'h11, 1'b1, 1'b0, 8'h00, 4'b0000, 4'd0, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0000, 8'h11, 1'b1, 1'b1, 8'hA2, 4'b0100, 4'd2, 1'b1};
        vecs[2]  = '{4'b0100, 4'b0000, 8'h22, 1'b1, 1'b1, 8'h11, 4'b0100, 4'd2, 1'b1};
        vecs[3]  = '{4'b0100, 4'b0100, 8'h33, 1'b1, 1'b1, 8'h22, 4'b0100, 4'd2, 1'b1};
        vecs[4]  = '{4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, 8'h33, 4'b0000, 4'd2, 1'b0};
        vecs[5]  = '{4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 8'h33, 4'b0000, 4'd2, 1'b0};
        vecs[6]  = '{4'b0101, 4'b0101, 8'h44, 1'b1, 1'b0, 8'h33, 4'b0000, 4'd2, 1'b0};
        vecs[7]  = '{4'b0101, 4'b0101, 8'h44, 1'b1, 1'b1, 8'hA0, 4'b0001, 4'd0, 1'b1};
        vecs[8]  = '{4'b0100, 4'b0100, 8'h44, 1'b1, 1'b1, 8'h44, 4'b0000, 4'd0, 1'b0};
        vecs[9]  = '{4'b0100, 4'b0100, 8'h44, 1'b1, 1'b1, 8'hA2, 4'b0100, 4'd2, 1'b1};
        vecs[10] = '{4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, 8'h44, 4'b0000, 4'd2, 1'b0};
        vecs[11] = '{4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, 8'h44, 4'b0000, 4'd2, 1'b0};
        vecs[12] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, 8'h44, 4'b0000, 4'd2, 1'b0};
        vecs[13] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 8'h44, 4'b0000, 4'd2, 1'b0};

        for (int i = 0; i < 14; i++) begin
            in_valid  = vecs[i].v;
            in_last   = vecs[i].l;
            in_data   = {4{vecs[i].d}};
            out_ready = vecs[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            check($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(vecs[i].od));
            check($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].ir));
            check($sformatf("vec%0d_grant", i),     32'(grant),     32'(vecs[i].g));
            check($sformatf("vec%0d_busy", i),      32'(busy),      32'(vecs[i].b));
            @(posedge clk); #1;
        end
        in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;

        // Burst cap: six bytes on port 3 split into two grants, no gap on the link.
        do_reset();
        clear_src();
        add_pkt(3, 6, 8'h01);
        build_expected();
        run_stream(100, "cap");
        if (cap_cyc.size() == 8) check("cap_contiguous", 32'(cap_cyc[7] - cap_cyc[0]), 32'd7);

        // Fairness: two ports streaming single-byte packets alternate.
        do_reset();
        clear_src();
        for (int k = 0; k < 5; k++) begin
            add_pkt(0, 1, 8'h10 + 8'(k));
            add_pkt(1, 1, 8'h20 + 8'(k));
        end
        build_expected();
        run_stream(100, "fair");

        // Randomized packets on every port under random backpressure.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            clear_src();
            for (int p = 0; p < TB_PORTS; p++) begin
                int npk;
                npk = $urandom_range(3);
                for (int k = 0; k < npk; k++)
                    add_pkt(p, $urandom_range(1, 6), 8'($urandom));
            end
            build_expected();
            run_stream(r == 0 ? 50 : $urandom_range(20, 90), $sformatf("rand%0d", r));
        end

        // Reset while a header is held under backpressure.
        do_reset();
        in_valid = 4'b0001; in_last = 4'b0001; in_data = 32'h0000_0077; out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre_out_valid", 32'(out_valid), 32'd1);
        check("rst_pre_out_data",  32'(out_data),  32'hA0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_grant",     32'(grant),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        @(posedge clk); #1 reset = 1'b0;
        clear_src();
        add_pkt(0, 1, 8'h77);
        build_expected();
        run_stream(100, "post_rst");

        // Header-less instance: port 1 sends 55 then 66, one IDLE cycle apart.
        @(posedge clk); #1;
        b_in_valid = 2'b10; b_in_last = 2'b10; b_in_data = 16'h5500; b_out_ready = 1'b1;
        @(negedge clk);
        check("nh_c0_out_valid", 32'(b_out_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("nh_c1_out_valid", 32'(b_out_valid), 32'd0);
        check("nh_c1_in_ready",  32'(b_in_ready),  32'b10);
        check("nh_c1_grant",     32'(b_grant),     32'd1);
        @(posedge clk); #1 b_in_data = 16'h6600;
        @(negedge clk);
        check("nh_c2_out_valid", 32'(b_out_valid), 32'd1);
        check("nh_c2_out_data",  32'(b_out_data),  32'h55);
        check("nh_c2_in_ready",  32'(b_in_ready),  32'd0);
        check("nh_c2_busy",      32'(b_busy),      32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("nh_c3_out_valid", 32'(b_out_valid), 32'd0);
        check("nh_c3_in_ready",  32'(b_in_ready),  32'b10);
        @(posedge clk); #1 b_in_valid = '0; b_in_last = '0;
        @(negedge clk);
        check("nh_c4_out_valid", 32'(b_out_valid), 32'd1);
        check("nh_c4_out_data",  32'(b_out_data),  32'h66);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
